// File: rtl/issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : issue_scheduler
// Description : Slot allocator and issue scheduler for a BS-entry instruction
//               buffer. Owns the dependency matrix (row i = slots that
//               instruction i waits on), allocates new instructions into the
//               lowest free slot, picks one ready instruction per cycle with
//               round-robin fairness and offers it on a registered valid/ready
//               issue port. Completion clears the finished slot's column in
//               every row and frees the slot.
// Ports       : clk, rst            - clock / async active-high reset
//               alloc_valid/deps    - new instruction and its dependency mask
//               alloc_ready/index   - free slot available / slot to be written
//               issue_valid/index   - registered issue offer
//               issue_ready         - downstream accepts the offer
//               complete_valid/index- an issued instruction finished
//               count/full/empty    - occupancy status
//               err                 - sticky illegal-completion flag
// Revision    : 1.0 - initial release
// ============================================================================
module issue_scheduler #(
    parameter  int BS = 16,
    localparam int IB = $clog2(BS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alloc_valid,
    input  logic [BS-1:0] alloc_deps,
    output logic          alloc_ready,
    output logic [IB-1:0] alloc_index,
    output logic          issue_valid,
    output logic [IB-1:0] issue_index,
    input  logic          issue_ready,
    input  logic          complete_valid,
    input  logic [IB-1:0] complete_index,
    output logic [IB:0]   count,
    output logic          full,
    output logic          empty,
    output logic          err
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [BS-1:0] occupied_q, occupied_d;
    logic [BS-1:0] issued_q,   issued_d;
    logic [BS-1:0] dep_q [BS];
    logic [BS-1:0] dep_d [BS];
    logic [IB-1:0] rr_q, rr_d;
    logic          issue_valid_q, issue_valid_d;
    logic [IB-1:0] issue_index_q, issue_index_d;
    logic [IB:0]   count_q, count_d;
    logic          err_q, err_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic          w_full;
    logic [IB-1:0] w_alloc_index;
    logic          w_alloc_fire;
    logic          w_issue_fire;
    logic          w_comp_ok;
    logic [BS-1:0] w_alloc_self;
    logic [BS-1:0] w_comp_bit;
    logic [BS-1:0] w_alloc_row;
    logic [BS-1:0] w_ready;
    logic          w_sel_found;
    logic [IB-1:0] w_sel_index;
    logic [IB-1:0] w_scan_idx;

    assign w_full      = (count_q == (IB+1)'(BS));
    assign alloc_ready = ~w_full;
    assign alloc_index = w_alloc_index;
    assign full        = w_full;
    assign empty       = (count_q == '0);
    assign count       = count_q;
    assign err         = err_q;
    assign issue_valid = issue_valid_q;
    assign issue_index = issue_index_q;

    // Lowest-numbered free slot; depends on registered occupancy only, so a
    // slot freed this cycle shows up here one cycle later.
    always_comb begin
        w_alloc_index = '0;
        for (int i = BS-1; i >= 0; i--) begin
            if (!occupied_q[i]) begin
                w_alloc_index = IB'(i);
            end
        end
    end

    assign w_alloc_fire = alloc_valid && !w_full;
    assign w_issue_fire = issue_valid_q && issue_ready;
    assign w_comp_ok    = complete_valid && occupied_q[complete_index]
                          && issued_q[complete_index];

    always_comb begin
        w_alloc_self                = '0;
        w_alloc_self[w_alloc_index] = 1'b1;
        w_comp_bit                  = '0;
        w_comp_bit[complete_index]  = w_comp_ok;
    end

    // Dependencies on free slots, on itself, or on the slot completing this
    // very cycle would never be cleared later, so they are dropped here.
    assign w_alloc_row = alloc_deps & occupied_q & ~w_alloc_self & ~w_comp_bit;

    // Ready slots; the one already sitting in the issue register is excluded
    // so a reload during a handshake never picks the slot being issued.
    always_comb begin
        for (int i = 0; i < BS; i++) begin
            w_ready[i] = occupied_q[i] && !issued_q[i] && (dep_q[i] == '0)
                         && !(issue_valid_q && (issue_index_q == IB'(i)));
        end
    end

    // Round-robin pick: first ready slot scanning upward from rr, wrapping.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_index = '0;
        w_scan_idx  = '0;
        for (int k = 0; k < BS; k++) begin
            w_scan_idx = rr_q + IB'(k);
            if (!w_sel_found && w_ready[w_scan_idx]) begin
                w_sel_found = 1'b1;
                w_sel_index = w_scan_idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        occupied_d    = occupied_q;
        issued_d      = issued_q;
        dep_d         = dep_q;
        rr_d          = rr_q;
        issue_valid_d = issue_valid_q;
        issue_index_d = issue_index_q;
        count_d       = count_q;
        err_d         = err_q;

        if (w_issue_fire) begin
            issued_d[issue_index_q] = 1'b1;
            rr_d                    = issue_index_q + 1'b1;
        end

        if (w_comp_ok) begin
            for (int i = 0; i < BS; i++) begin
                dep_d[i][complete_index] = 1'b0;
            end
            occupied_d[complete_index] = 1'b0;
            issued_d[complete_index]   = 1'b0;
        end else if (complete_valid) begin
            err_d = 1'b1;
        end

        // A valid completion always targets an occupied slot, so it can never
        // collide with the free slot being allocated.
        if (w_alloc_fire) begin
            occupied_d[w_alloc_index] = 1'b1;
            issued_d[w_alloc_index]   = 1'b0;
            dep_d[w_alloc_index]      = w_alloc_row;
        end

        case ({w_alloc_fire, w_comp_ok})
            2'b10:   count_d = count_q + (IB+1)'(1);
            2'b01:   count_d = count_q - (IB+1)'(1);
            default: count_d = count_q;
        endcase

        // Issue register reloads when empty or when its offer is taken.
        if (!issue_valid_q || w_issue_fire) begin
            issue_valid_d = w_sel_found;
            if (w_sel_found) begin
                issue_index_d = w_sel_index;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupied_q    <= '0;
            issued_q      <= '0;
            for (int i = 0; i < BS; i++) begin
                dep_q[i] <= '0;
            end
            rr_q          <= '0;
            issue_valid_q <= 1'b0;
            issue_index_q <= '0;
            count_q       <= '0;
            err_q         <= 1'b0;
        end else begin
            occupied_q    <= occupied_d;
            issued_q      <= issued_d;
            dep_q         <= dep_d;
            rr_q          <= rr_d;
            issue_valid_q <= issue_valid_d;
            issue_index_q <= issue_index_d;
            count_q       <= count_d;
            err_q         <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_issue_scheduler
// Description : Self-checking bench for issue_scheduler: directed scenarios
//               followed by random traffic, all compared against a
//               behavioural model of the slot table.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_issue_scheduler;

    localparam int BS = 16;
    localparam int IB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          alloc_valid;
    logic [BS-1:0] alloc_deps;
    logic          alloc_ready;
    logic [IB-1:0] alloc_index;
    logic          issue_valid;
    logic [IB-1:0] issue_index;
    logic          issue_ready;
    logic          complete_valid;
    logic [IB-1:0] complete_index;
    logic [IB:0]   count;
    logic          full;
    logic          empty;
    logic          err;

    issue_scheduler #(.BS(BS)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_valid    (alloc_valid),
        .alloc_deps     (alloc_deps),
        .alloc_ready    (alloc_ready),
        .alloc_index    (alloc_index),
        .issue_valid    (issue_valid),
        .issue_index    (issue_index),
        .issue_ready    (issue_ready),
        .complete_valid (complete_valid),
        .complete_index (complete_index),
        .count          (count),
        .full           (full),
        .empty          (empty),
        .err            (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: the slot table as plain arrays
    // ------------------------------------------------------------------
    bit          m_occ [BS];
    bit          m_iss [BS];
    logic [15:0] m_dep [BS];
    int          m_rr;
    bit          m_iv;
    int          m_idx;
    bit          m_err;

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < BS; i++) c += m_occ[i] ? 1 : 0;
        return c;
    endfunction

    function automatic int m_free_slot();
        for (int i = 0; i < BS; i++) if (!m_occ[i]) return i;
        return -1;
    endfunction

    function automatic bit m_is_ready(input int s);
        return m_occ[s] && !m_iss[s] && (m_dep[s] == 16'h0) && !(m_iv && m_idx == s);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < BS; i++) begin
            m_occ[i] = 0; m_iss[i] = 0; m_dep[i] = '0;
        end
        m_rr = 0; m_iv = 0; m_idx = 0; m_err = 0;
    endtask

    task automatic m_step(input bit av, input logic [15:0] ad, input bit ir,
                          input bit cv, input int ci);
        bit          fire, hs, cok, found, load;
        int          ai, sel, s;
        logic [15:0] occv, row;
        fire  = av && (m_count() < BS);
        ai    = m_free_slot();
        hs    = m_iv && ir;
        cok   = cv && m_occ[ci] && m_iss[ci];
        load  = !m_iv || hs;
        found = 0;
        sel   = 0;
        for (int k = 0; k < BS; k++) begin
            s = (m_rr + k) % BS;
            if (!found && m_is_ready(s)) begin found = 1; sel = s; end
        end
        for (int i = 0; i < BS; i++) occv[i] = m_occ[i];

        if (hs) begin
            m_iss[m_idx] = 1;
            m_rr = (m_idx + 1) % BS;
        end
        if (cok) begin
            for (int i = 0; i < BS; i++) m_dep[i][ci] = 1'b0;
            m_occ[ci] = 0;
            m_iss[ci] = 0;
        end else if (cv) begin
            m_err = 1;
        end
        if (fire) begin
            row = ad & occv;
            row[ai] = 1'b0;
            if (cok) row[ci] = 1'b0;
            m_occ[ai] = 1;
            m_iss[ai] = 0;
            m_dep[ai] = row;
        end
        if (load) begin
            m_iv = found;
            if (found) m_idx = sel;
        end
    endtask

    task automatic compare_all();
        check_val("alloc_ready", alloc_ready, m_count() < BS);
        if (m_count() < BS) check_val("alloc_index", alloc_index, m_free_slot());
        check_val("issue_valid", issue_valid, m_iv);
        if (m_iv) check_val("issue_index", issue_index, m_idx);
        check_val("count", count, m_count());
        check_val("full", full, m_count() == BS);
        check_val("empty", empty, m_count() == 0);
        check_val("err", err, m_err);
    endtask

    // Values seen on the DUT just before the active edge of the last step
    bit          pre_hs;
    logic [IB-1:0] pre_idx;
    bit          pre_ar;

    task automatic step(input bit av, input logic [15:0] ad, input bit ir,
                        input bit cv, input int ci);
        alloc_valid    = av;
        alloc_deps     = ad;
        issue_ready    = ir;
        complete_valid = cv;
        complete_index = IB'(ci);
        pre_hs  = issue_valid && ir;
        pre_idx = issue_index;
        pre_ar  = alloc_ready;
        m_step(av, ad, ir, cv, ci);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic reset_dut();
        alloc_valid = 0; alloc_deps = '0; issue_ready = 0;
        complete_valid = 0; complete_index = '0;
        rst = 1'b1;
        #2;
        m_reset();
        compare_all();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        compare_all();
    endtask

    int n_hs, first_c, last_c, cyc, cnt_before;
    bit          r_av, r_ir, r_cv;
    logic [15:0] r_ad;
    int          r_ci, n_cand;
    int          cand [BS];

    initial begin
        rst = 1'b1;
        alloc_valid = 0; alloc_deps = '0; issue_ready = 0;
        complete_valid = 0; complete_index = '0;
        m_reset();
        #1;

        // ---- Fill with zero-dep instructions, issue 0..15 one per cycle
        reset_dut();
        check_val("rst_alloc_index", alloc_index, 0);
        check_val("rst_alloc_ready", alloc_ready, 1);
        check_val("rst_empty", empty, 1);
        n_hs = 0; first_c = -1; last_c = -1; cyc = 0;
        for (int k = 0; k < 16; k++) begin
            check_val("fill_alloc_index", alloc_index, k);
            step(1, 16'h0, 1, 0, 0);
            cyc++;
            if (pre_hs) begin
                check_val("fill_issue_order", pre_idx, n_hs);
                if (first_c < 0) first_c = cyc;
                last_c = cyc; n_hs++;
            end
        end
        check_val("fill_full", full, 1);
        check_val("fill_alloc_ready", alloc_ready, 0);
        for (int t = 0; t < 40 && n_hs < 16; t++) begin
            step(0, 16'h0, 1, 0, 0);
            cyc++;
            if (pre_hs) begin
                check_val("fill_issue_order", pre_idx, n_hs);
                if (first_c < 0) first_c = cyc;
                last_c = cyc; n_hs++;
            end
        end
        check_val("fill_issue_total", n_hs, 16);
        check_val("fill_back_to_back", last_c - first_c, 15);

        // ---- Dependency chain 0 <- 1 <- 2
        reset_dut();
        n_hs = 0;
        step(1, 16'h0000, 1, 0, 0); if (pre_hs) n_hs++;
        step(1, 16'h0001, 1, 0, 0); if (pre_hs) n_hs++;
        step(1, 16'h0002, 1, 0, 0); if (pre_hs) begin n_hs++; check_val("chain_first", pre_idx, 0); end
        for (int t = 0; t < 4; t++) begin
            step(0, 16'h0, 1, 0, 0);
            if (pre_hs) begin n_hs++; check_val("chain_first", pre_idx, 0); end
        end
        check_val("chain_only_slot0", n_hs, 1);
        check_val("chain_idle", issue_valid, 0);
        step(0, 16'h0, 1, 1, 0);
        check_val("chain_c_edge", issue_valid, 0);
        step(0, 16'h0, 0, 0, 0);
        check_val("chain_slot1_valid", issue_valid, 1);
        check_val("chain_slot1_index", issue_index, 1);
        step(0, 16'h0, 1, 0, 0);
        check_val("chain_slot1_hs", pre_hs, 1);
        step(0, 16'h0, 1, 1, 1);
        check_val("chain_c2_edge", issue_valid, 0);
        step(0, 16'h0, 0, 0, 0);
        check_val("chain_slot2_valid", issue_valid, 1);
        check_val("chain_slot2_index", issue_index, 2);

        // ---- Back-pressure hold, then back-to-back release
        reset_dut();
        for (int k = 0; k < 3; k++) step(1, 16'h0, 0, 0, 0);
        for (int t = 0; t < 5; t++) begin
            step(0, 16'h0, 0, 0, 0);
            check_val("hold_valid", issue_valid, 1);
            check_val("hold_index", issue_index, 0);
        end
        for (int k = 0; k < 3; k++) begin
            step(0, 16'h0, 1, 0, 0);
            check_val("release_hs", pre_hs, 1);
            check_val("release_order", pre_idx, k);
        end
        check_val("release_drained", issue_valid, 0);

        // ---- Same-cycle completion of 3 and allocation into 5 depending on 3
        reset_dut();
        for (int k = 0; k < 5; k++) step(1, 16'h0, 1, 0, 0);
        for (int t = 0; t < 4; t++) step(0, 16'h0, 1, 0, 0);
        check_val("cc_alloc_index", alloc_index, 5);
        cnt_before = count;
        step(1, 16'h0008, 0, 1, 3);
        check_val("cc_count_same", count, cnt_before);
        check_val("cc_freed_visible", alloc_index, 3);
        step(0, 16'h0, 0, 0, 0);
        check_val("cc_slot5_valid", issue_valid, 1);
        check_val("cc_slot5_index", issue_index, 5);

        // ---- Illegal completion, then reset mid-stream
        step(0, 16'h0, 0, 1, 7);
        check_val("err_set", err, 1);
        check_val("err_count", count, cnt_before);
        step(0, 16'h0, 0, 0, 0);
        step(0, 16'h0, 0, 0, 0);
        check_val("err_sticky", err, 1);
        check_val("err_table_kept", issue_index, 5);
        reset_dut();
        check_val("mid_rst_err", err, 0);
        check_val("mid_rst_count", count, 0);
        check_val("mid_rst_issue_valid", issue_valid, 0);
        check_val("mid_rst_alloc_index", alloc_index, 0);

        // ---- Full buffer: freed slot visible only in the following cycle
        for (int k = 0; k < 16; k++) step(1, 16'h0, 1, 0, 0);
        for (int t = 0; t < 4; t++) step(0, 16'h0, 1, 0, 0);
        check_val("full_before", alloc_ready, 0);
        step(1, 16'h0, 1, 1, 4);
        check_val("full_same_cycle_ready", pre_ar, 0);
        check_val("full_after_ready", alloc_ready, 1);
        check_val("full_after_index", alloc_index, 4);
        check_val("full_after_count", count, 15);

        // ---- Random traffic against the model
        reset_dut();
        for (int t = 0; t < 3000; t++) begin
            r_av = ($urandom % 3) != 0;
            r_ad = 16'($urandom) & 16'($urandom);
            r_ir = ($urandom % 4) != 0;
            n_cand = 0;
            for (int i = 0; i < BS; i++) begin
                if (m_occ[i] && m_iss[i]) begin cand[n_cand] = i; n_cand++; end
            end
            r_cv = 0; r_ci = 0;
            if (n_cand > 0 && ($urandom % 2) == 1) begin
                r_cv = 1;
                r_ci = cand[$urandom % n_cand];
            end
            if (t > 2500 && ($urandom % 200) == 0) begin
                r_cv = 1;
                r_ci = $urandom % BS;
            end
            step(r_av, r_ad, r_ir, r_cv, r_ci);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/issue_scheduler.md
# issue_scheduler

Slot allocator and issue scheduler for the BS-entry instruction buffer. It owns the dependency matrix: row i lists the slots that instruction i waits on. It accepts new instructions into free slots, selects one ready instruction per cycle with round-robin fairness, and presents it on a valid/ready issue port. On completion it clears the finished slot's column in every row and frees the slot.

## Interface
- BS, 16, number of buffer slots; power of two, ≥2
- IB, $clog2(BS), slot index width (derived, not overridable)
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- alloc_valid  input  1  new instruction offered
- alloc_deps  input  BS  bit j = new instruction depends on slot j
- alloc_ready  output  1  a free slot exists (= !full)
- alloc_index  output  IB  slot that will be written; lowest-numbered free slot; meaningful only while alloc_ready
- issue_valid  output  1  registered; issue_index holds a ready slot
- issue_index  output  IB  registered slot being offered for issue
- issue_ready  input  1  downstream accepts the issue
- complete_valid  input  1  an issued instruction finished
- complete_index  input  IB  slot that finished
- count  output  IB+1  occupied slots
- full  output  1  count == BS
- empty  output  1  count == 0
- err  output  1  sticky; completion to a slot that is not occupied-and-issued

## Operation
- Per-slot state: occupied, issued, dep row[BS-1:0]. Round-robin pointer rr (IB bits).
- Allocation fires on alloc_valid && alloc_ready. It sets occupied[alloc_index]=1 and issued=0. The row is written as alloc_deps & occupied & ~self-bit, with the completing slot's bit also cleared if a completion fires in the same cycle. Dependencies on free or self slots are dropped.
- Ready vector: occupied & ~issued & (row==0), excluding the slot currently held in the issue register.
- Selection: first ready slot scanning upward from rr, wrapping modulo BS.
- Issue register: loads the selected candidate when issue_valid==0, or when the issue handshake fires. Otherwise it holds issue_valid and issue_index stable.
- Issue handshake (issue_valid && issue_ready): sets issued[issue_index]=1 and rr = issue_index+1 (mod BS). The next candidate loads in the same edge, so back-to-back issue every cycle is possible.
- Completion fires on complete_valid. It must target an occupied, issued slot; otherwise err is set and nothing else changes. A valid completion clears bit complete_index in every row, and clears occupied and issued for that slot.
- A slot freed by completion is not visible to alloc_index until the next cycle.
- Allocation and completion in the same cycle: both take effect.
- count: +1 on allocation, −1 on valid completion, unchanged when both occur in the same cycle.

## Timing
- Reset values: all occupied/issued 0, rows 0, rr 0, issue_valid 0, issue_index 0, count 0, full 0, empty 1, err 0, alloc_ready 1, alloc_index 0.
- alloc_ready, alloc_index, full and empty are combinational from registered state only; there is no combinational path from any input.
- Zero-dependency allocation accepted at edge E0 → candidate at E1 → issue_valid high after E1. Latency is 1 cycle after acceptance.
- Completion at edge C of the last dependency → dependent instruction eligible in cycle C+1 → issue_valid for it after edge C+1 at the earliest.
- While issue_valid is high and issue_ready is low, issue_index must not change.
- Reset asserted mid-operation clears everything immediately (async). Pending issue and buffered entries are discarded.

## Test plan
- Reset, then 16 allocations with zero deps, issue_ready=1 → alloc_index 0..15 in order, full=1 after the 16th, alloc_ready=0; issues 0,1,…,15, one per cycle.
- Chain: slot 0 with deps 0, slot 1 with deps 0x0001, slot 2 with deps 0x0002 → only slot 0 issues. Completing 0 lets slot 1 issue 2 cycles later, then slot 2 the same way.
- Hold issue_ready=0 for 5 cycles with 3 ready slots → issue_index stable for the 5 cycles. Releasing it issues 0,1,2 back-to-back with rr advancing.
- Completion of slot 3 and allocation into free slot 5 with deps 0x0008 in the same cycle → slot 5 stored row 0, issues next; count unchanged.
- Completion to unoccupied slot 7 → err=1 stays set; count and table unchanged. Then assert rst mid-stream → all outputs return to reset values.
- Full buffer: complete slot 4 → alloc_index=4 and alloc_ready=1 in the following cycle, not the same cycle.
